// File: rtl/press_count_pkg.sv
// Shared types and constants for the press-count scheduler.
package press_count_pkg;

   // Per-button debounce state.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS_W = 2'd1,
      HELD    = 2'd2,
      REL_W   = 2'd3
   } deb_state_t;

   // Per-button direction encoding on btn_dir.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with stability timer,
// and a one-cycle press pulse on the first cycle the FSM sits in HELD.
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);
   import press_count_pkg::*;

   localparam int TIMER_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

   logic               sync1_r;
   logic               sync2_r;
   deb_state_t         state_r;
   deb_state_t         state_s;
   logic [TIMER_W-1:0] timer_r;
   logic [TIMER_W-1:0] timer_s;
   logic               press_r;
   logic               press_s;

   // Bring the raw active-low pin into the clock domain as an active-high level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= ~btn_n;
         sync2_r <= sync1_r;
      end
   end

   // Next-state and timer logic: a level change is accepted only after it stays stable.
   always_comb begin
      state_s = state_r;
      timer_s = timer_r;
      case (state_r)
         IDLE: begin
            if (sync2_r) begin
               state_s = PRESS_W;
               timer_s = TIMER_ZERO;
            end else begin
               state_s = IDLE;
               timer_s = TIMER_ZERO;
            end
         end
         PRESS_W: begin
            if (!sync2_r) begin
               state_s = IDLE;
               timer_s = TIMER_ZERO;
            end else if (timer_r == TIMER_LAST) begin
               state_s = HELD;
               timer_s = TIMER_ZERO;
            end else begin
               state_s = PRESS_W;
               timer_s = timer_r + TIMER_ONE;
            end
         end
         HELD: begin
            if (!sync2_r) begin
               state_s = REL_W;
               timer_s = TIMER_ZERO;
            end else begin
               state_s = HELD;
               timer_s = TIMER_ZERO;
            end
         end
         REL_W: begin
            if (sync2_r) begin
               state_s = HELD;
               timer_s = TIMER_ZERO;
            end else if (timer_r == TIMER_LAST) begin
               state_s = IDLE;
               timer_s = TIMER_ZERO;
            end else begin
               state_s = REL_W;
               timer_s = timer_r + TIMER_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            timer_s = TIMER_ZERO;
         end
      endcase
   end

   // Only the PRESS_W -> HELD transition produces a request; bounces back from REL_W do not.
   always_comb begin
      press_s = (state_r == PRESS_W) && (state_s == HELD);
   end

   // State, timer and registered one-shot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
         timer_r <= TIMER_ZERO;
         press_r <= 1'b0;
      end else begin
         state_r <= state_s;
         timer_r <= timer_s;
         press_r <= press_s;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/press_count_scheduler.sv
// Shares one up/down counter among NUM_BTN debounced buttons. Presses are latched
// as pending requests and a round-robin arbiter services one per cycle.
module press_count_scheduler #(
   parameter int NUM_BTN         = 4,
   parameter int COUNT_W         = 7,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit WRAP            = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_n,
   input  logic [NUM_BTN-1:0] btn_dir,
   input  logic               clear,
   output logic [COUNT_W-1:0] count,
   output logic [COUNT_W-1:0] count_n,
   output logic [NUM_BTN-1:0] grant,
   output logic               update,
   output logic [NUM_BTN-1:0] pending,
   output logic               wrap_flag
);
   import press_count_pkg::*;

   localparam int PTR_W = $clog2(NUM_BTN);
   localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};
   localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
   localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
   localparam logic [PTR_W-1:0]   PTR_ZERO   = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_BTN - 1);
   localparam logic [NUM_BTN-1:0] BTN_ZERO   = {NUM_BTN{1'b0}};
   localparam logic [NUM_BTN-1:0] BTN_ONE    = NUM_BTN'(1);

   // Requester index 'offset' positions after 'base', modulo NUM_BTN.
   function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_BTN) begin
         sum = sum - NUM_BTN;
      end else begin
         sum = sum;
      end
      return PTR_W'(sum);
   endfunction

   logic [NUM_BTN-1:0] press_s;
   logic [NUM_BTN-1:0] pending_r;
   logic [NUM_BTN-1:0] pending_nx_s;
   logic [NUM_BTN-1:0] service_s;
   logic [NUM_BTN-1:0] grant_r;
   logic [PTR_W-1:0]   ptr_r;
   logic [PTR_W-1:0]   ptr_nx_s;
   logic [PTR_W-1:0]   sel_s;
   logic               found_s;
   logic               dir_s;
   logic [COUNT_W-1:0] count_r;
   logic [COUNT_W-1:0] count_nx_s;
   logic               hit_s;
   logic               update_r;
   logic               wrap_r;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
         debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_chan (
            .clk  (clk),
            .reset(reset),
            .btn_n(btn_n[gi]),
            .press(press_s[gi])
         );
      end
   endgenerate

   // Round-robin pick: first pending requester at or after the pointer.
   always_comb begin
      found_s = 1'b0;
      sel_s   = PTR_ZERO;
      for (int k = 0; k < NUM_BTN; k++) begin
         if (!found_s && pending_r[rr_index(ptr_r, k)]) begin
            found_s = 1'b1;
            sel_s   = rr_index(ptr_r, k);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Service mask, pointer advance and next pending set; a new press overrides its own service.
   always_comb begin
      if (found_s) begin
         service_s = BTN_ONE << sel_s;
      end else begin
         service_s = BTN_ZERO;
      end
      if (sel_s == PTR_LAST) begin
         ptr_nx_s = PTR_ZERO;
      end else begin
         ptr_nx_s = sel_s + PTR_W'(1);
      end
      pending_nx_s = (pending_r & ~service_s) | press_s;
   end

   // Counter step for the selected requester; hit_s marks reaching a limit.
   always_comb begin
      dir_s      = btn_dir[sel_s];
      count_nx_s = count_r;
      hit_s      = 1'b0;
      case (dir_s)
         DIR_UP: begin
            if (count_r == COUNT_MAX) begin
               hit_s      = 1'b1;
               count_nx_s = WRAP ? COUNT_ZERO : COUNT_MAX;
            end else begin
               count_nx_s = count_r + COUNT_ONE;
            end
         end
         DIR_DOWN: begin
            if (count_r == COUNT_ZERO) begin
               hit_s      = 1'b1;
               count_nx_s = WRAP ? COUNT_MAX : COUNT_ZERO;
            end else begin
               count_nx_s = count_r - COUNT_ONE;
            end
         end
         default: begin
            hit_s      = 1'b0;
            count_nx_s = count_r;
         end
      endcase
   end

   // Pending, arbitration and counter state; clear wipes everything but the pointer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pending_r <= BTN_ZERO;
         ptr_r     <= PTR_ZERO;
         count_r   <= COUNT_ZERO;
         grant_r   <= BTN_ZERO;
         update_r  <= 1'b0;
         wrap_r    <= 1'b0;
      end else if (clear) begin
         pending_r <= BTN_ZERO;
         count_r   <= COUNT_ZERO;
         grant_r   <= BTN_ZERO;
         update_r  <= 1'b0;
         wrap_r    <= 1'b0;
      end else begin
         pending_r <= pending_nx_s;
         if (found_s) begin
            count_r  <= count_nx_s;
            grant_r  <= service_s;
            update_r <= 1'b1;
            ptr_r    <= ptr_nx_s;
            if (hit_s) begin
               wrap_r <= 1'b1;
            end
         end else begin
            grant_r  <= BTN_ZERO;
            update_r <= 1'b0;
         end
      end
   end

   assign count     = count_r;
   assign count_n   = ~count_r;
   assign grant     = grant_r;
   assign update    = update_r;
   assign pending   = pending_r;
   assign wrap_flag = wrap_r;

endmodule

// File: tb/tb_press_count_scheduler.sv
// Directed bench: two schedulers (WRAP=1 and WRAP=0) share one set of stimulus.
module tb_press_count_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn_n = 4'hF;
   logic [3:0] btn_dir = 4'h0;
   logic       clear = 1'b0;

   logic [6:0] count_a, count_n_a, count_b, count_n_b;
   logic [3:0] grant_a, pend_a, grant_b, pend_b;
   logic       upd_a, wrap_a, upd_b, wrap_b;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int upd_a_cnt = 0;
   int upd_b_cnt = 0;
   int nlog = 0;
   logic [3:0] glog [16];
   int         clog [16];
   logic [3:0] plog [16];
   logic [3:0] prev_pend;

   press_count_scheduler #(.NUM_BTN(4), .COUNT_W(7), .DEBOUNCE_CYCLES(4), .WRAP(1'b1)) dut_a (
      .clk(clk), .reset(reset), .btn_n(btn_n), .btn_dir(btn_dir), .clear(clear),
      .count(count_a), .count_n(count_n_a), .grant(grant_a), .update(upd_a),
      .pending(pend_a), .wrap_flag(wrap_a)
   );

   press_count_scheduler #(.NUM_BTN(4), .COUNT_W(7), .DEBOUNCE_CYCLES(4), .WRAP(1'b0)) dut_b (
      .clk(clk), .reset(reset), .btn_n(btn_n), .btn_dir(btn_dir), .clear(clear),
      .count(count_b), .count_n(count_n_b), .grant(grant_b), .update(upd_b),
      .pending(pend_b), .wrap_flag(wrap_b)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample 1 time unit after the rising edge, log every update of dut_a.
   task automatic tick();
      prev_pend = pend_a;
      @(posedge clk);
      #1;
      cyc++;
      if (upd_a === 1'b1) begin
         upd_a_cnt++;
         if (nlog < 16) begin
            glog[nlog] = grant_a;
            clog[nlog] = cyc;
            plog[nlog] = prev_pend;
            nlog++;
         end
      end
      if (upd_b === 1'b1) upd_b_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_log();
      upd_a_cnt = 0;
      upd_b_cnt = 0;
      nlog = 0;
   endtask

   task automatic press(input logic [3:0] mask, input logic [3:0] dirs);
      btn_dir = dirs;
      btn_n = ~mask;
      run(14);
      btn_n = 4'hF;
      run(14);
   endtask

   task automatic check_reset_state(input string tag);
      check_value({tag, "_count"}, count_a, 7'h00);
      check_value({tag, "_count_n"}, count_n_a, 7'h7F);
      check_value({tag, "_grant"}, grant_a, 4'h0);
      check_value({tag, "_update"}, upd_a, 1'b0);
      check_value({tag, "_pending"}, pend_a, 4'h0);
      check_value({tag, "_wrap"}, wrap_a, 1'b0);
      check_value({tag, "_count_b"}, count_b, 7'h00);
   endtask

   initial begin
      // 1. Reset with all buttons pressed
      reset = 1'b0;
      btn_n = 4'b0000;
      @(posedge clk); #1;
      run(3);
      check_reset_state("rst");
      btn_n = 4'hF;
      reset = 1'b1;
      run(4);

      // 2. Single up press on button 0
      clear_log();
      press(4'b0001, 4'b0001);
      check_value("single_updates", upd_a_cnt, 1);
      check_value("single_grant", glog[0], 4'b0001);
      check_value("single_pend_before", plog[0], 4'b0001);
      check_value("single_count", count_a, 7'h01);
      check_value("single_count_n", count_n_a, 7'h7E);
      check_value("single_count_b", count_b, 7'h01);
      check_value("single_pend_after", pend_a, 4'h0);

      // 3. Bouncing button 1, then a stable hold
      clear_log();
      btn_dir = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         btn_n = 4'b1101;
         run(2);
         btn_n = 4'hF;
         run(2);
      end
      btn_n = 4'b1101;
      run(8);
      btn_n = 4'hF;
      run(14);
      check_value("bounce_updates", upd_a_cnt, 1);
      check_value("bounce_count", count_a, 7'h02);
      check_value("bounce_count_b", count_b, 7'h02);

      // 4. Simultaneous presses from pointer 0: grants 0,1,2 on consecutive cycles
      reset = 1'b0;
      run(2);
      reset = 1'b1;
      check_reset_state("rst2");
      clear_log();
      press(4'b0111, 4'b0101);
      check_value("rr_updates", upd_a_cnt, 3);
      check_value("rr_grant0", glog[0], 4'b0001);
      check_value("rr_grant1", glog[1], 4'b0010);
      check_value("rr_grant2", glog[2], 4'b0100);
      check_value("rr_consec1", clog[1] - clog[0], 1);
      check_value("rr_consec2", clog[2] - clog[1], 1);
      check_value("rr_count", count_a, 7'h01);
      check_value("rr_count_b", count_b, 7'h01);

      // 5a. Down to zero, then below zero
      press(4'b0001, 4'b0000);
      check_value("down_count", count_a, 7'h00);
      check_value("down_wrap", wrap_a, 1'b0);
      clear_log();
      press(4'b0001, 4'b0000);
      check_value("under_count_a", count_a, 7'h7F);
      check_value("under_count_n_a", count_n_a, 7'h00);
      check_value("under_wrap_a", wrap_a, 1'b1);
      check_value("under_count_b", count_b, 7'h00);
      check_value("under_wrap_b", wrap_b, 1'b1);
      check_value("under_upd_b", upd_b_cnt, 1);
      press(4'b0001, 4'b0001);
      check_value("over_count_a", count_a, 7'h00);
      check_value("over_wrap_a", wrap_a, 1'b1);
      check_value("over_count_b", count_b, 7'h01);

      // 6a. Clear on the cycle a grant would occur
      btn_dir = 4'b0001;
      btn_n = 4'b1110;
      for (int i = 0; i < 30 && pend_a[0] !== 1'b1; i++) tick();
      check_value("clr_pend_seen", pend_a[0], 1'b1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_value("clr_count_a", count_a, 7'h00);
      check_value("clr_count_b", count_b, 7'h00);
      check_value("clr_update", upd_a, 1'b0);
      check_value("clr_grant", grant_a, 4'h0);
      check_value("clr_pending", pend_a, 4'h0);
      check_value("clr_wrap_a", wrap_a, 1'b0);
      check_value("clr_wrap_b", wrap_b, 1'b0);
      clear_log();
      run(6);
      btn_n = 4'hF;
      run(14);
      check_value("clr_no_update", upd_a_cnt, 0);
      check_value("clr_count_hold", count_a, 7'h00);

      // 5b. Ramp to the top, then one more up press
      for (int r = 0; r < 31; r++) press(4'hF, 4'hF);
      press(4'b0111, 4'hF);
      check_value("ramp_count_a", count_a, 7'h7F);
      check_value("ramp_count_b", count_b, 7'h7F);
      check_value("ramp_wrap_a", wrap_a, 1'b0);
      clear_log();
      press(4'b0001, 4'hF);
      check_value("top_count_a", count_a, 7'h00);
      check_value("top_wrap_a", wrap_a, 1'b1);
      check_value("top_count_b", count_b, 7'h7F);
      check_value("top_wrap_b", wrap_b, 1'b1);
      check_value("top_upd_b", upd_b_cnt, 1);

      // 6b. Reset while button 0 is in PRESS_W and still held afterwards
      btn_dir = 4'b0001;
      btn_n = 4'b1110;
      run(4);
      reset = 1'b0;
      run(2);
      reset = 1'b1;
      check_value("midrst_count_b", count_b, 7'h00);
      check_value("midrst_wrap_b", wrap_b, 1'b0);
      clear_log();
      run(16);
      check_value("midrst_updates", upd_a_cnt, 1);
      check_value("midrst_count", count_a, 7'h01);
      btn_n = 4'hF;
      run(14);
      check_value("midrst_once", upd_a_cnt, 1);
      check_value("midrst_count_b2", count_b, 7'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
